// File: rtl/kbd_event_fifo.sv
// Keyboard press-event queue: per-key pending latches feed a show-ahead FIFO of
// 2-bit key codes, one event per cycle, lowest key index first.
module kbd_event_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [3:0]               key_pulse,
  output logic                     evt_valid,
  output logic [1:0]               evt_code,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);

  logic [3:0]            r_pending;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [DEPTH-1:0][1:0] r_mem;

  logic [3:0] w_grant;
  logic [1:0] w_widx;
  logic       w_pop;
  logic       w_wr;
  logic       w_full;

  assign w_full = (r_count == CNT_FULL);
  assign w_pop  = (r_count != '0) && evt_ready;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_wr   = (r_pending != 4'b0) && (!w_full || w_pop);

  always_comb begin
    w_widx  = 2'd0;
    w_grant = 4'b0;
    for (int i = 3; i >= 0; i--) begin
      if (r_pending[i]) w_widx = 2'(i);
    end
    if (w_wr) w_grant[w_widx] = 1'b1;
  end

  // A press is lost only when it lands on a pending bit that is not leaving now.
  assign drop      = |(key_pulse & r_pending & ~w_grant);
  assign evt_valid = (r_count != '0);
  assign evt_code  = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= 4'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_mem     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | key_pulse;
      if (w_wr) begin
        r_mem[r_wptr] <= w_widx;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo: per-scenario tasks with a code scoreboard checked on
// every accepted pop, plus inline occupancy/latency/drop checks.
module tb_kbd_event_fifo;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rstn;
  logic [3:0] key_pulse;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;
  logic [3:0] count;
  logic       drop;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] sb[$];

  kbd_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_pulse (key_pulse),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .count     (count),
    .drop      (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rstn && evt_valid && evt_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got code %0d, expected no event", evt_code);
      end else begin
        logic [1:0] exp_code;
        exp_code = sb.pop_front();
        if (evt_code !== exp_code) begin
          n_fail++;
          $display("FAIL pop_code: got %0d, expected %0d", evt_code, exp_code);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    evt_ready = 1'b1;
    while ((evt_valid || sb.size() != 0) && guard < 60) begin
      tick();
      guard++;
    end
    evt_ready = 1'b0;
    tick();
    tick();
    n_tests++;
    if (sb.size() != 0 || evt_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_drain: left=%0d valid=%b count=%0d, expected 0/0/0",
               nm, sb.size(), evt_valid, count);
    end
  endtask

  task automatic pulse_key0(input int n, input bit push);
    for (int k = 0; k < n; k++) begin
      key_pulse = 4'b0001;
      if (push) sb.push_back(2'd0);
      tick();
      key_pulse = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    key_pulse = 4'hF;
    evt_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (evt_valid !== 1'b0 || count !== 4'd0 || drop !== 1'b0 || evt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b count=%0d drop=%b code=%0d, expected 0/0/0/0",
               evt_valid, count, drop, evt_code);
    end
    key_pulse = 4'h0;
    evt_ready = 1'b0;
    rstn = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (evt_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_ignore_pulse: valid=%b count=%0d, expected 0/0", evt_valid, count);
    end
  endtask

  task automatic test_single();
    evt_ready = 1'b0;
    key_pulse = 4'b0100;
    sb.push_back(2'd2);
    tick();
    key_pulse = 4'b0000;
    n_tests++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c1_valid: got %b, expected 0", evt_valid);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL single_c2: valid=%b code=%0d count=%0d, expected 1/2/1",
               evt_valid, evt_code, count);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd2) begin
      n_fail++;
      $display("FAIL single_hold: valid=%b code=%0d, expected 1/2", evt_valid, evt_code);
    end
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++;
    if (evt_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL single_c4: valid=%b count=%0d, expected 0/0", evt_valid, count);
    end
  endtask

  task automatic test_simul();
    logic [1:0] exp_seq[3];
    bit saw_drop;
    exp_seq = '{2'd0, 2'd1, 2'd3};
    saw_drop = 1'b0;
    evt_ready = 1'b1;
    key_pulse = 4'b1011;
    foreach (exp_seq[j]) sb.push_back(exp_seq[j]);
    #1 saw_drop |= drop;
    tick();
    key_pulse = 4'b0000;
    #1 saw_drop |= drop;
    tick();
    for (int j = 0; j < 3; j++) begin
      saw_drop |= drop;
      n_tests++;
      if (evt_valid !== 1'b1 || evt_code !== exp_seq[j]) begin
        n_fail++;
        $display("FAIL simul_seq%0d: valid=%b code=%0d, expected 1/%0d",
                 j, evt_valid, evt_code, exp_seq[j]);
      end
      tick();
    end
    n_tests++;
    if (evt_valid !== 1'b0 || saw_drop) begin
      n_fail++;
      $display("FAIL simul_end: valid=%b drop_seen=%b, expected 0/0", evt_valid, saw_drop);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_empty_ready();
    evt_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (count !== 4'd0 || evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_ready_idle: count=%0d valid=%b, expected 0/0", count, evt_valid);
    end
    key_pulse = 4'b1000;
    sb.push_back(2'd3);
    tick();
    key_pulse = 4'b0000;
    tick();
    n_tests++;
    if (evt_valid !== 1'b1 || evt_code !== 2'd3) begin
      n_fail++;
      $display("FAIL empty_ready_head: valid=%b code=%0d, expected 1/3", evt_valid, evt_code);
    end
    tick();
    n_tests++;
    if (evt_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_ready_after: valid=%b count=%0d, expected 0/0", evt_valid, count);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_grant_collision();
    evt_ready = 1'b0;
    key_pulse = 4'b0100;
    sb.push_back(2'd2);
    tick();
    key_pulse = 4'b0100;
    sb.push_back(2'd2);
    #1;
    n_tests++;
    if (drop !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_drop: got %b, expected 0", drop);
    end
    tick();
    key_pulse = 4'b0000;
    tick();
    n_tests++;
    if (count !== 4'd2) begin
      n_fail++;
      $display("FAIL collision_count: got %0d, expected 2", count);
    end
    drain("collision");
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    pulse_key0(8, 1'b1);
    key_pulse = 4'b0001;
    sb.push_back(2'd0);
    #1;
    n_tests++;
    if (drop !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_9th_drop: got %b, expected 0", drop);
    end
    tick();
    key_pulse = 4'b0000;
    tick();
    n_tests++;
    if (count !== 4'd8 || evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_full: count=%0d valid=%b, expected 8/1", count, evt_valid);
    end
    key_pulse = 4'b0001;
    #1;
    n_tests++;
    if (drop !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_10th_drop: got %b, expected 1", drop);
    end
    tick();
    key_pulse = 4'b0000;
    #1;
    n_tests++;
    if (drop !== 1'b0 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL ovf_after: drop=%b count=%0d, expected 0/8", drop, count);
    end
    drain("ovf");
  endtask

  task automatic test_full_pop();
    evt_ready = 1'b0;
    pulse_key0(8, 1'b1);
    n_tests++;
    if (count !== 4'd8) begin
      n_fail++;
      $display("FAIL fullpop_fill: count=%0d, expected 8", count);
    end
    key_pulse = 4'b0010;
    sb.push_back(2'd1);
    tick();
    key_pulse = 4'b0000;
    tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    n_tests++;
    if (count !== 4'd8) begin
      n_fail++;
      $display("FAIL fullpop_count: count=%0d, expected 8", count);
    end
    tick();
    n_tests++;
    if (count !== 4'd8 || evt_code !== 2'd0) begin
      n_fail++;
      $display("FAIL fullpop_hold: count=%0d code=%0d, expected 8/0", count, evt_code);
    end
    drain("fullpop");
  endtask

  task automatic test_reset_mid();
    bit saw_valid;
    evt_ready = 1'b0;
    pulse_key0(4, 1'b0);
    key_pulse = 4'b0011;
    tick();
    key_pulse = 4'b0001;
    tick();
    key_pulse = 4'b0000;
    n_tests++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL rstmid_pre: count=%0d, expected 5", count);
    end
    rstn = 1'b0;
    sb.delete();
    #1;
    n_tests++;
    if (count !== 4'd0 || evt_valid !== 1'b0 || drop !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_async: count=%0d valid=%b drop=%b, expected 0/0/0",
               count, evt_valid, drop);
    end
    tick();
    rstn = 1'b1;
    evt_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (6) begin
      tick();
      saw_valid |= evt_valid;
    end
    n_tests++;
    if (saw_valid || count !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_after: valid_seen=%b count=%0d, expected 0/0", saw_valid, count);
    end
    evt_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    key_pulse = 4'h0;
    evt_ready = 1'b0;
    test_reset();
    test_single();
    test_simul();
    test_empty_ready();
    test_grant_collision();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
